// File: rtl/hough_pipe_pkg.sv
// Shared types and default geometry for the Hough pipeline stages.
package hough_pipe_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_t;

    localparam int DEF_IMAGE_BITS = 8;
    localparam int DEF_MATRIX_N   = 120;
    localparam int DEF_MATRIX_M   = 120;

endpackage

// File: rtl/raster_counter.sv
// Raster-order X/Y counter: X wraps at MATRIX_N-1 and carries into Y.
// o_last flags the final pixel (MATRIX_N-1, MATRIX_M-1) from the registers.
module raster_counter #(
    parameter int MATRIX_N = 120,
    parameter int MATRIX_M = 120
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_clear,
    input  logic                        i_advance,
    output logic [$clog2(MATRIX_N)-1:0] o_x,
    output logic [$clog2(MATRIX_M)-1:0] o_y,
    output logic                        o_last
);

    localparam int XW = $clog2(MATRIX_N);
    localparam int YW = $clog2(MATRIX_M);
    localparam logic [XW-1:0] X_LAST = XW'(MATRIX_N - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(MATRIX_M - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_advance) begin
            if (r_x == X_LAST) begin
                r_x <= '0;
                r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = (r_x == X_LAST) && (r_y == Y_LAST);

endmodule

// File: rtl/overlay_streamer.sv
// Captures a full image + overlay frame and streams it pixel by pixel with ready/valid.
// Define OVERLAY_BLEND_EN to substitute OVERLAY_VALUE wherever the overlay bit is set.
//
// state  | meaning
// IDLE   | waiting for ReqIn; captures the frame on the first edge it is high
// STREAM | presenting buffered pixels in raster order until the last one transfers
module overlay_streamer
    import hough_pipe_pkg::*;
#(
    parameter int                    IMAGE_BITS    = DEF_IMAGE_BITS,
    parameter int                    MATRIX_N      = DEF_MATRIX_N,
    parameter int                    MATRIX_M      = DEF_MATRIX_M,
    parameter logic [IMAGE_BITS-1:0] OVERLAY_VALUE = '1
) (
    input  logic                                     Clk,
    input  logic                                     Reset,
    input  logic [IMAGE_BITS*MATRIX_N*MATRIX_M-1:0]  ImgMatIn,
    input  logic [MATRIX_N*MATRIX_M-1:0]             OverlayMatIn,
    input  logic                                     ReqIn,
    output logic                                     AckIn,
    input  logic                                     PixReady,
    output logic                                     PixValid,
    output logic [IMAGE_BITS-1:0]                    PixOut,
    output logic                                     PixOverlay,
    output logic [$clog2(MATRIX_N)-1:0]              PixX,
    output logic [$clog2(MATRIX_M)-1:0]              PixY,
    output logic                                     FrameEnd
);

    localparam int PIXELS = MATRIX_N * MATRIX_M;
    localparam int XW     = $clog2(MATRIX_N);
    localparam int YW     = $clog2(MATRIX_M);
    localparam int IW     = $clog2(PIXELS);

`ifdef OVERLAY_BLEND_EN
    localparam bit BLEND = 1'b1;
`else
    localparam bit BLEND = 1'b0;
`endif

    stream_state_t r_state;
    stream_state_t w_next;

    logic [IMAGE_BITS-1:0] r_pix [PIXELS];
    logic [PIXELS-1:0]     r_ovl;
    logic                  r_ack;

    logic          w_capture;
    logic          w_xfer;
    logic          w_valid;
    logic          w_last;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    logic [IW-1:0] w_idx;
    logic [IMAGE_BITS-1:0] w_buf_pix;
    logic                  w_buf_ovl;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (ReqIn) w_next = STREAM;
            STREAM:  if (PixReady && w_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_valid   = (r_state == STREAM);
        w_capture = (r_state == IDLE) && ReqIn;
        w_xfer    = (r_state == STREAM) && PixReady;
    end

    raster_counter #(
        .MATRIX_N (MATRIX_N),
        .MATRIX_M (MATRIX_M)
    ) u_raster (
        .clk       (Clk),
        .rst       (Reset),
        .i_clear   (w_capture),
        .i_advance (w_xfer),
        .o_x       (w_x),
        .o_y       (w_y),
        .o_last    (w_last)
    );

    // Frame buffer is loaded only in IDLE so upstream may change its inputs mid-stream.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < PIXELS; k++) r_pix[k] <= '0;
            r_ovl <= '0;
        end else if (w_capture) begin
            for (int k = 0; k < PIXELS; k++) r_pix[k] <= ImgMatIn[k*IMAGE_BITS +: IMAGE_BITS];
            r_ovl <= OverlayMatIn;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= w_capture;
        end
    end

    assign w_idx     = IW'(w_y) * IW'(MATRIX_N) + IW'(w_x);
    assign w_buf_pix = r_pix[w_idx];
    assign w_buf_ovl = r_ovl[w_idx];

    assign AckIn      = r_ack;
    assign PixValid   = w_valid;
    assign PixOut     = !w_valid ? '0 : ((BLEND && w_buf_ovl) ? OVERLAY_VALUE : w_buf_pix);
    assign PixOverlay = w_valid & w_buf_ovl;
    assign PixX       = w_valid ? w_x : '0;
    assign PixY       = w_valid ? w_y : '0;
    assign FrameEnd   = w_valid & w_last;

endmodule

// File: tb/tb_overlay_streamer.sv
// Directed + randomized bench for overlay_streamer on a 4x3 frame of 8-bit pixels;
// expected pixels come from a per-frame snapshot of the inputs taken at capture.
module tb_overlay_streamer;

    localparam int IB   = 8;
    localparam int N    = 4;
    localparam int M    = 3;
    localparam int NPIX = N * M;

`ifdef OVERLAY_BLEND_EN
    localparam bit BLEND = 1'b1;
`else
    localparam bit BLEND = 1'b0;
`endif

    logic              Clk;
    logic              Reset;
    logic [IB*NPIX-1:0] ImgMatIn;
    logic [NPIX-1:0]   OverlayMatIn;
    logic              ReqIn;
    logic              AckIn;
    logic              PixReady;
    logic              PixValid;
    logic [IB-1:0]     PixOut;
    logic              PixOverlay;
    logic [1:0]        PixX;
    logic [1:0]        PixY;
    logic              FrameEnd;

    int vectors;
    int miscompares;

    logic [IB-1:0] cap_img [NPIX];
    logic          cap_ovl [NPIX];

    overlay_streamer #(
        .IMAGE_BITS (IB),
        .MATRIX_N   (N),
        .MATRIX_M   (M)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .ImgMatIn     (ImgMatIn),
        .OverlayMatIn (OverlayMatIn),
        .ReqIn        (ReqIn),
        .AckIn        (AckIn),
        .PixReady     (PixReady),
        .PixValid     (PixValid),
        .PixOut       (PixOut),
        .PixOverlay   (PixOverlay),
        .PixX         (PixX),
        .PixY         (PixY),
        .FrameEnd     (FrameEnd)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, PixValid, 0);
        chk({tag, "_ack"}, AckIn, 0);
        chk({tag, "_pix"}, PixOut, 0);
        chk({tag, "_ovl"}, PixOverlay, 0);
        chk({tag, "_x"}, PixX, 0);
        chk({tag, "_y"}, PixY, 0);
        chk({tag, "_fe"}, FrameEnd, 0);
    endtask

    task automatic load_ramp_frame();
        for (int i = 0; i < NPIX; i++) ImgMatIn[i*IB +: IB] = IB'(i);
        OverlayMatIn = 12'h020;
    endtask

    task automatic load_random_frame();
        for (int i = 0; i < NPIX; i++) ImgMatIn[i*IB +: IB] = IB'($urandom);
        OverlayMatIn = NPIX'($urandom);
    endtask

    function automatic logic [IB-1:0] exp_pix(input int k);
        return (BLEND && cap_ovl[k]) ? 8'hFF : cap_img[k];
    endfunction

    // mode: 0 = always ready, 1 = ready toggling 1/0, 2 = random ready.
    // abort_at >= 0 asserts Reset once that many pixels have transferred.
    task automatic do_frame(input int mode, input bit hold, input int abort_at, input int exp_cycles);
        int  k;
        int  cyc;
        bit  rdy;
        bit  first;
        ReqIn = 1'b1;
        for (int i = 0; i < NPIX; i++) begin
            cap_img[i] = ImgMatIn[i*IB +: IB];
            cap_ovl[i] = OverlayMatIn[i];
        end
        @(negedge Clk);
        chk("ack_pulse", AckIn, 1);
        ReqIn = hold;
        load_random_frame();
        k = 0;
        cyc = 0;
        first = 1'b1;
        while (k < NPIX && cyc < 200) begin
            if (k == abort_at) begin
                PixReady = 1'b0;
                Reset = 1'b1;
                #1;
                chk_all_zero("abort");
                return;
            end
            chk("valid", PixValid, 1);
            chk("x", PixX, k % N);
            chk("y", PixY, k / N);
            chk("pix", PixOut, exp_pix(k));
            chk("ovl", PixOverlay, cap_ovl[k]);
            chk("frame_end", FrameEnd, (k == NPIX - 1) ? 1 : 0);
            if (!first) chk("ack_low", AckIn, 0);
            first = 1'b0;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            PixReady = rdy;
            @(negedge Clk);
            cyc++;
            if (rdy) k++;
        end
        chk("frame_done", k, NPIX);
        chk("post_valid", PixValid, 0);
        chk("post_fe", FrameEnd, 0);
        chk("post_ack", AckIn, 0);
        if (exp_cycles > 0) chk("frame_cycles", cyc, exp_cycles);
        PixReady = 1'b0;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        Reset        = 1'b1;
        ReqIn        = 1'b0;
        PixReady     = 1'b0;
        ImgMatIn     = '0;
        OverlayMatIn = '0;

        repeat (2) @(negedge Clk);
        chk_all_zero("reset");
        Reset = 1'b0;
        repeat (2) begin
            @(negedge Clk);
            chk("idle_valid", PixValid, 0);
            chk("idle_ack", AckIn, 0);
        end

        load_ramp_frame();
        do_frame(0, 1'b0, -1, NPIX);

        load_ramp_frame();
        do_frame(1, 1'b0, -1, 2 * NPIX - 1);

        load_random_frame();
        do_frame(0, 1'b1, -1, NPIX);
        do_frame(0, 1'b1, -1, NPIX);
        do_frame(0, 1'b0, -1, NPIX);

        repeat (3) begin
            @(negedge Clk);
            chk("gap_valid", PixValid, 0);
            chk("gap_ack", AckIn, 0);
        end

        repeat (3) begin
            load_random_frame();
            do_frame(2, 1'b0, -1, 0);
        end

        load_ramp_frame();
        do_frame(0, 1'b0, 7, 0);
        @(negedge Clk);
        chk_all_zero("in_reset");
        Reset = 1'b0;
        repeat (4) begin
            @(negedge Clk);
            chk("after_reset_valid", PixValid, 0);
            chk("after_reset_ack", AckIn, 0);
        end

        load_ramp_frame();
        do_frame(1, 1'b0, -1, 2 * NPIX - 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
